ler_pixels: RTL and testbench
=============================

Name: ler_pixels

Overview:
- Read-side companion to the pixel writer on the VGA frame memory (4096 x 1-bit, synchronous read port).
- On a start pulse, fetches WORD_W consecutive pixels beginning at a base address and packs them into one word, LSB = first pixel.
- Serves the coprocessor datapath, which needs 32-pixel words back from the frame buffer.
- Issues one read per cycle, pipelined against the fixed RAM read latency; start/done handshake.

Parameters:
- ADDR_W, 12, frame-memory address width (depth 2^ADDR_W).
- WORD_W, 32, pixels gathered per transaction (1..2^ADDR_W).
- RD_LATENCY, 2, clock cycles from rdaddress/rden to valid q (≥1; 2 = registered RAM output).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- endereco_base  in  ADDR_W  first pixel address; latched when start is accepted.
- q  in  1  RAM read data.
- rdaddress  out  ADDR_W  RAM read address.
- rden  out  1  RAM read enable.
- dados_out  out  WORD_W  assembled pixel word.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - rdaddress, rden, dados_out, busy, done, issue counter, capture counter and valid pipeline all 0.
- States: IDLE, ISSUE, DRAIN, FIM.
- IDLE:
  - start=1 at edge of cycle 0 → latch base, clear issue and capture counters → ISSUE.
  - dados_out is not cleared; it holds the previous result until the first new capture.
- ISSUE (cycles 1..WORD_W):
  - rden=1, rdaddress = base + k for k = 0..WORD_W-1, one per cycle.
  - Address addition is modulo 2^ADDR_W, so base=4095 wraps to 0.
  - After issuing k=WORD_W-1 → DRAIN.
- Valid pipeline:
  - rden is delayed through a RD_LATENCY-deep shift register.
  - When the delayed valid is 1, q is written into dados_out[capture counter] and the counter increments.
  - Bits not yet captured keep their old value.
- DRAIN:
  - rden=0 and rdaddress holds its last value.
  - Once WORD_W bits have been captured → FIM.
- FIM: done=1 for exactly one cycle, busy=0 from this cycle, → IDLE.
- Latency: start accepted at cycle 0 → done high in cycle WORD_W+RD_LATENCY+1 (35 with defaults). dados_out is final in that cycle and stable until the next accepted start.
- busy=1 in ISSUE and DRAIN only.
- start while not in IDLE: ignored, with no queuing. start held high across FIM re-triggers in the following IDLE cycle (level-sensitive in IDLE).
- endereco_base changes after acceptance have no effect.
- Reset mid-operation: abort immediately. In-flight RAM returns are discarded because the valid pipeline is cleared, and dados_out=0.
- q is ignored whenever the delayed valid is 0.

Decomposition:
- Shared package (vga_pkg): ADDR_W, frame depth, and the state encoding constants IDLE/ISSUE/DRAIN/FIM.
- These constants are shared with the writer block.
- One natural sub-module: linha_atraso, a parameterised RD_LATENCY-deep 1-bit valid delay line with asynchronous active-low clear.

Test Plan:
- RAM model with RD_LATENCY=2 preloaded with pixel(a)=a[0]^a[3]; base=0x010, start pulse → done in cycle 35, dados_out=expected pattern (bit i = pixel(0x010+i)), rden high for exactly 32 cycles.
- Wrap-around: base=0xFF0 → rdaddress sequence 0xFF0..0xFFF,0x000..0x00F; dados_out matches those addresses.
- start pulsed again at cycle 10 with a different base → ignored; single done at cycle 35; result from the original base.
- Assert reset_n=0 at cycle 20 → all outputs 0 asynchronously. Release, then new start with base=0x100 → clean 32-bit result, no stale bits.
- start held high for 80 cycles → two back-to-back transactions; done pulses in cycles 35 and 71; dados_out stable between the final capture and the next first capture.
- Parameter sweep RD_LATENCY=1 and WORD_W=8 → done at cycle 10, 8 correct bits.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-memory blocks (pixel writer and reader).
package vga_pkg;

    localparam int VGA_ADDR_W = 12;
    localparam int VGA_DEPTH  = 1 << VGA_ADDR_W;

    // Controller states, common to the writer and the reader.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIM   = 2'd3
    } estado_t;

endpackage

// File: rtl/linha_atraso.sv
// DEPTH-deep 1-bit delay line with asynchronous active-low clear.
// Used to line up the read-valid with the RAM read latency.
module linha_atraso #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_vld_pipe;

    // Shift the valid bit one stage per clock; clearing drops any in-flight reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    assign o_q = r_vld_pipe[DEPTH-1];

endmodule

// File: rtl/ler_pixels.sv
// Frame-memory reader: gathers WORD_W consecutive 1-bit pixels into one word,
// LSB = first pixel, issuing one pipelined read per cycle.
module ler_pixels
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int WORD_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] endereco_base,
    input  logic              q,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    output logic [WORD_W-1:0] dados_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(WORD_W + 1);

    estado_t       r_state;
    estado_t       w_next;
    logic [CW-1:0] r_iss_cnt;
    logic [CW-1:0] r_cap_cnt;
    logic          w_vld;
    logic          w_last_iss;
    logic          w_last_cap;

    // Read-valid delayed to the cycle in which q carries the addressed pixel.
    linha_atraso #(.DEPTH(RD_LATENCY)) u_atraso (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (rden),
        .o_q     (w_vld)
    );

    assign w_last_iss = (r_iss_cnt == CW'(WORD_W - 1));
    assign w_last_cap = w_vld && (r_cap_cnt == CW'(WORD_W - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and status outputs; the last capture moves straight to FIM.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = ISSUE;
            ISSUE: begin
                busy = 1'b1;
                if (w_last_iss) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_last_cap) w_next = FIM;
            end
            FIM: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Read issue: base latched into the address register on acceptance, then
    // incremented (wrapping at 2^ADDR_W) once per cycle; counters track progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdaddress <= '0;
            rden      <= 1'b0;
            r_iss_cnt <= '0;
            r_cap_cnt <= '0;
        end else begin
            if (w_vld) r_cap_cnt <= r_cap_cnt + 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    rdaddress <= endereco_base;
                    rden      <= 1'b1;
                    r_iss_cnt <= '0;
                    r_cap_cnt <= '0;
                end
                ISSUE: begin
                    if (w_last_iss) begin
                        rden <= 1'b0;
                    end else begin
                        rdaddress <= rdaddress + 1'b1;
                        r_iss_cnt <= r_iss_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture q into the bit selected by the capture counter; other bits hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dados_out <= '0;
        end else if (w_vld) begin
            for (int i = 0; i < WORD_W; i++)
                if (r_cap_cnt == CW'(i)) dados_out[i] <= q;
        end
    end

endmodule

// File: tb/tb_ler_pixels.sv
// Directed bench for ler_pixels: default build (32 px, latency 2) plus an
// 8 px / latency 1 build, each against its own frame-memory model.
module tb_ler_pixels;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [11:0] endereco_base;
    logic        q;
    logic [11:0] rdaddress;
    logic        rden;
    logic [31:0] dados_out;
    logic        busy;
    logic        done;

    logic        start8;
    logic [11:0] base8;
    logic        q8;
    logic [11:0] rdaddress8;
    logic        rden8;
    logic [7:0]  dados8;
    logic        busy8;
    logic        done8;

    int checks = 0;
    int errors = 0;

    logic mem [0:4095];
    logic ram_s1;

    ler_pixels u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .endereco_base(endereco_base),
        .q(q), .rdaddress(rdaddress), .rden(rden), .dados_out(dados_out),
        .busy(busy), .done(done)
    );

    ler_pixels #(.WORD_W(8), .RD_LATENCY(1)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .endereco_base(base8),
        .q(q8), .rdaddress(rdaddress8), .rden(rden8), .dados_out(dados8),
        .busy(busy8), .done(done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Frame memory: pixel(a) = a[0] ^ a[3]
    initial begin
        for (int a = 0; a < 4096; a++) begin
            logic [11:0] av;
            av = 12'(a);
            mem[a] = av[0] ^ av[3];
        end
    end

    // Two-cycle registered RAM for the default build, one-cycle for the 8 px build.
    always @(posedge clock) begin
        ram_s1 <= mem[rdaddress];
        q      <= ram_s1;
        q8     <= mem[rdaddress8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    // Called #1 after an edge (cycle 0). Runs ncyc cycles, counting rden cycles,
    // checking the address sequence and recording done pulses.
    task automatic txn(input logic [11:0] base, input int pulse_at, input logic [11:0] pulse_base,
                       input int ncyc, output int done_cyc, output int done_cnt,
                       output int rden_cnt, output int addr_err);
        logic [11:0] ea;
        done_cyc = -1; done_cnt = 0; rden_cnt = 0; addr_err = 0;
        start = 1'b1;
        endereco_base = base;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            start = 1'b0;
            endereco_base = ~base;
            if (c == pulse_at) begin
                start = 1'b1;
                endereco_base = pulse_base;
            end
            if (rden) begin
                ea = base + 12'(rden_cnt);
                if (rdaddress !== ea) addr_err++;
                rden_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, dn, rc, ae;
        int d1, d2, dcount, wait_n;
        logic [31:0] dados_a;

        reset_n = 1'b0; start = 1'b0; endereco_base = '0;
        start8 = 1'b0; base8 = '0;
        repeat (3) step();
        chk("rst_rden", 32'(rden), 32'h0);
        chk("rst_addr", 32'(rdaddress), 32'h0);
        chk("rst_dados", dados_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        step();

        // Basic read from base 0x010: period-16 pattern 0x55AA
        txn(12'h010, -1, 12'h0, 40, dc, dn, rc, ae);
        chk("t1_done_cyc", 32'(dc), 32'd35);
        chk("t1_done_cnt", 32'(dn), 32'd1);
        chk("t1_rden_cnt", 32'(rc), 32'd32);
        chk("t1_addr_err", 32'(ae), 32'd0);
        chk("t1_dados", dados_out, 32'h55AA55AA);
        chk("t1_busy", 32'(busy), 32'h0);
        repeat (5) step();
        chk("t1_hold", dados_out, 32'h55AA55AA);

        // Wrap-around: 0xFF0..0xFFF, 0x000..0x00F
        txn(12'hFF0, -1, 12'h0, 40, dc, dn, rc, ae);
        chk("t2_done_cyc", 32'(dc), 32'd35);
        chk("t2_rden_cnt", 32'(rc), 32'd32);
        chk("t2_addr_err", 32'(ae), 32'd0);
        chk("t2_last_addr", 32'(rdaddress), 32'h00F);
        chk("t2_dados", dados_out, 32'h55AA55AA);

        // Base 0x013 (pattern rotated by 3); restart at cycle 10 must be ignored
        txn(12'h013, 10, 12'h010, 40, dc, dn, rc, ae);
        chk("t3_done_cyc", 32'(dc), 32'd35);
        chk("t3_done_cnt", 32'(dn), 32'd1);
        chk("t3_rden_cnt", 32'(rc), 32'd32);
        chk("t3_addr_err", 32'(ae), 32'd0);
        chk("t3_dados", dados_out, 32'h4AB54AB5);

        // Reset mid-transaction at cycle 20
        start = 1'b1; endereco_base = 12'h003;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("t4_rden", 32'(rden), 32'h0);
        chk("t4_addr", 32'(rdaddress), 32'h0);
        chk("t4_dados", dados_out, 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        txn(12'h100, -1, 12'h0, 40, dc, dn, rc, ae);
        chk("t4_new_done_cyc", 32'(dc), 32'd35);
        chk("t4_new_rden_cnt", 32'(rc), 32'd32);
        chk("t4_new_dados", dados_out, 32'h55AA55AA);

        // start held high: back-to-back transactions, second latches base 0x003
        d1 = -1; d2 = -1; dcount = 0; dados_a = '0;
        start = 1'b1; endereco_base = 12'h010;
        for (int c = 1; c <= 79; c++) begin
            step();
            if (c == 36) endereco_base = 12'h003;
            if (done && c <= 71) begin
                dcount++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 35) dados_a = dados_out;
            if (c == 39) chk("t5_stable", dados_out, dados_a);
            if (c == 71) chk("t5_dados_b", dados_out, 32'h4AB54AB5);
        end
        start = 1'b0;
        chk("t5_done1", 32'(d1), 32'd35);
        chk("t5_done2", 32'(d2), 32'd71);
        chk("t5_done_cnt", 32'(dcount), 32'd2);
        chk("t5_dados_a", dados_a, 32'h55AA55AA);
        wait_n = 0;
        while ((busy || done) && wait_n < 100) begin
            step();
            wait_n++;
        end
        chk("t5_idle_timeout", 32'(wait_n < 100), 32'h1);

        // 8 px, latency 1, base 0x005: pixels 5..12 = 1,0,1,1,0,1,0,1
        dc = -1; dn = 0;
        start8 = 1'b1; base8 = 12'h005;
        for (int c = 1; c <= 15; c++) begin
            step();
            start8 = 1'b0;
            base8 = 12'hFFF;
            if (done8) begin
                dn++;
                if (dc < 0) dc = c;
            end
        end
        chk("t6_done_cyc", 32'(dc), 32'd10);
        chk("t6_done_cnt", 32'(dn), 32'd1);
        chk("t6_dados", 32'(dados8), 32'h000000AD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
